// File: rtl/fetch_unit_pkg.sv
// Shared pipeline package: default widths, bubble encoding and the
// pipeline-control bundle exchanged with the hazard unit.
package fetch_unit_pkg;

  localparam int          DEF_ADDR_W   = 12;
  localparam int          DEF_INSN_W   = 16;
  localparam int          DEF_CNT_W    = 16;
  localparam logic [15:0] DEF_NOP_INSN = 16'h0000;

  // Bit order of the hazard unit's control bundle, LSB first.
  localparam int CTRL_PC_WRITE_BIT    = 0;
  localparam int CTRL_IF_ID_WRITE_BIT = 1;
  localparam int CTRL_IF_ID_FLUSH_BIT = 2;
  localparam int CTRL_W               = 3;

  // Packed view of the same bundle (MSB first, matching the bit numbers above).
  typedef struct packed {
    logic if_id_flush;
    logic if_id_write;
    logic pc_write;
  } pipe_ctrl_t;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module sat_counter
  import fetch_unit_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, synchronous instruction-RAM
// addressing, IF/ID pipeline register with bubbles, debug event counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSN_W   = DEF_INSN_W,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(DEF_NOP_INSN),
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              if_id_flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [INSN_W-1:0] if_id_ir,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_ctrl_t ctrl;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] if_id_ir_q, if_id_ir_d;
  logic [ADDR_W-1:0] if_id_pc1_q, if_id_pc1_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              rd_ok_q;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_next;

  assign ctrl.pc_write    = pc_write;
  assign ctrl.if_id_write = if_id_write;
  assign ctrl.if_id_flush = if_id_flush;

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_next  = branch_taken ? branch_target : pc_plus1;

  // Present next PC early so the RAM output lines up with the pc register
  // one cycle later; a stall re-reads the current word.
  assign imem_addr = !reset ? '0 :
                     (state && ctrl.pc_write) ? pc_next : pc_q;

  // Next-state for PC and IF/ID; flush beats write, stopped state freezes all.
  always_comb begin
    pc_d          = pc_q;
    if_id_ir_d    = if_id_ir_q;
    if_id_pc1_d   = if_id_pc1_q;
    if_id_valid_d = if_id_valid_q;
    if (state) begin
      if (ctrl.pc_write) begin
        pc_d = pc_next;
      end
      if (ctrl.if_id_flush) begin
        if_id_ir_d    = NOP_INSN;
        if_id_valid_d = 1'b0;
      end else if (ctrl.if_id_write) begin
        if_id_ir_d    = rd_ok_q ? imem_rdata : NOP_INSN;
        if_id_valid_d = rd_ok_q;
        if_id_pc1_d   = pc_plus1;
      end
    end
  end

  // Pipeline state registers; rd_ok marks RAM data valid once out of reset,
  // independent of the running state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= '0;
      if_id_ir_q    <= NOP_INSN;
      if_id_pc1_q   <= '0;
      if_id_valid_q <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_ir_q    <= if_id_ir_d;
      if_id_pc1_q   <= if_id_pc1_d;
      if_id_valid_q <= if_id_valid_d;
      rd_ok_q       <= 1'b1;
    end
  end

  assign pc          = pc_q;
  assign if_id_ir    = if_id_ir_q;
  assign if_id_pc1   = if_id_pc1_q;
  assign if_id_valid = if_id_valid_q;

  // Event counters: index 0 fetch, 1 stall, 2 flush.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign cnt_inc[0] = state && ctrl.if_id_write && !ctrl.if_id_flush && rd_ok_q;
  assign cnt_inc[1] = state && !ctrl.if_id_write && !ctrl.if_id_flush;
  assign cnt_inc[2] = state && ctrl.if_id_flush;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign fetch_cnt = cnt_val[0];
  assign stall_cnt = cnt_val[1];
  assign flush_cnt = cnt_val[2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the main run, hand-written
// sequences for freeze, saturation and mid-run reset.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        state;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [11:0] pc;
  logic [15:0] if_id_ir;
  logic [11:0] if_id_pc1;
  logic        if_id_valid;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .state         (state),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .if_id_ir      (if_id_ir),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction RAM, mem[i] = i + 0x100.
  logic [15:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i + 'h100);
  end
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        pw, iw, fl, bt;
    logic [11:0] tgt;
    logic [11:0] e_pc;
    logic [15:0] e_ir;
    logic [11:0] e_pc1;
    logic        e_v;
    logic [15:0] e_f, e_s, e_fl;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic bt, logic [11:0] tgt,
                              logic [11:0] e_pc, logic [15:0] e_ir, logic [11:0] e_pc1,
                              logic e_v, logic [15:0] e_f, logic [15:0] e_s, logic [15:0] e_fl);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.bt = bt; v.tgt = tgt;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_pc1 = e_pc1; v.e_v = e_v;
    v.e_f = e_f; v.e_s = e_s; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] e_pc, input logic [15:0] e_ir,
                           input logic [11:0] e_pc1, input logic e_v, input logic [15:0] e_f,
                           input logic [15:0] e_s, input logic [15:0] e_fl);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".ir"}, 32'(if_id_ir), 32'(e_ir));
    chk({tag, ".pc1"}, 32'(if_id_pc1), 32'(e_pc1));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_v));
    chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(e_f));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e_s));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e_fl));
    $display("%s: pc=%03h ir=%04h pc1=%03h v=%0d f=%0d s=%0d fl=%0d",
             tag, pc, if_id_ir, if_id_pc1, if_id_valid, fetch_cnt, stall_cnt, flush_cnt);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl, input logic bt,
                       input logic [11:0] tgt);
    pc_write = pw; if_id_write = iw; if_id_flush = fl; branch_taken = bt; branch_target = tgt;
  endtask

  initial begin
    // Running from pc=0 with all enables, stall at pc=5, branch at pc=8,
    // flush without pc_write, ignored branch, wrap through 0xFFF.
    vecs[0]  = mk(1,1,0,0,12'h000, 12'h001,16'h0100,12'h001,1, 1,0,0);
    vecs[1]  = mk(1,1,0,0,12'h000, 12'h002,16'h0101,12'h002,1, 2,0,0);
    vecs[2]  = mk(1,1,0,0,12'h000, 12'h003,16'h0102,12'h003,1, 3,0,0);
    vecs[3]  = mk(1,1,0,0,12'h000, 12'h004,16'h0103,12'h004,1, 4,0,0);
    vecs[4]  = mk(1,1,0,0,12'h000, 12'h005,16'h0104,12'h005,1, 5,0,0);
    vecs[5]  = mk(0,0,0,0,12'h000, 12'h005,16'h0104,12'h005,1, 5,1,0);
    vecs[6]  = mk(0,0,0,0,12'h000, 12'h005,16'h0104,12'h005,1, 5,2,0);
    vecs[7]  = mk(1,1,0,0,12'h000, 12'h006,16'h0105,12'h006,1, 6,2,0);
    vecs[8]  = mk(1,1,0,0,12'h000, 12'h007,16'h0106,12'h007,1, 7,2,0);
    vecs[9]  = mk(1,1,0,0,12'h000, 12'h008,16'h0107,12'h008,1, 8,2,0);
    vecs[10] = mk(1,1,1,1,12'h040, 12'h040,16'h0000,12'h008,0, 8,2,1);
    vecs[11] = mk(1,1,0,0,12'h000, 12'h041,16'h0140,12'h041,1, 9,2,1);
    vecs[12] = mk(0,0,1,0,12'h000, 12'h041,16'h0000,12'h041,0, 9,2,2);
    vecs[13] = mk(1,1,0,0,12'h000, 12'h042,16'h0141,12'h042,1, 10,2,2);
    vecs[14] = mk(0,1,0,1,12'h123, 12'h042,16'h0142,12'h043,1, 11,2,2);
    vecs[15] = mk(1,1,1,1,12'hFFE, 12'hFFE,16'h0000,12'h043,0, 11,2,3);
    vecs[16] = mk(1,1,0,0,12'h000, 12'hFFF,16'h10FE,12'hFFF,1, 12,2,3);
    vecs[17] = mk(1,1,0,0,12'h000, 12'h000,16'h10FF,12'h000,1, 13,2,3);
    vecs[18] = mk(1,1,0,0,12'h000, 12'h001,16'h0100,12'h001,1, 14,2,3);

    reset = 1'b0; state = 1'b0;
    drive(0,0,0,0,12'h000);
    step();
    // Controls active during reset must not move the RAM address.
    state = 1'b1;
    drive(1,1,0,0,12'h000);
    #1;
    chk("reset.imem_addr", 32'(imem_addr), 32'h0);
    step();
    step();
    check_all("reset", 12'h000, 16'h0000, 12'h000, 0, 0, 0, 0);

    // Release reset while stopped: only rd_ok may change.
    state = 1'b0;
    drive(0,0,0,0,12'h000);
    reset = 1'b1;
    step();
    check_all("release", 12'h000, 16'h0000, 12'h000, 0, 0, 0, 0);

    state = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].bt, vecs[i].tgt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_pc1,
                vecs[i].e_v, vecs[i].e_f, vecs[i].e_s, vecs[i].e_fl);
    end

    // Stopped for 3 cycles with random controls: everything frozen.
    state = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
      #1;
      chk($sformatf("freeze%0d.imem_addr", i), 32'(imem_addr), 32'h001);
      step();
      check_all($sformatf("freeze%0d", i), 12'h001, 16'h0100, 12'h001, 1, 14, 2, 3);
    end

    state = 1'b1;
    drive(1,1,0,0,12'h000);
    step();
    check_all("resume", 12'h002, 16'h0101, 12'h002, 1, 15, 2, 3);

    // Long stall to push stall_cnt from 2 up to 0xFFFE, then saturate.
    drive(0,0,0,0,12'h000);
    for (int i = 0; i < 65532; i++) @(posedge clock);
    #1;
    check_all("sat_pre", 12'h002, 16'h0101, 12'h002, 1, 15, 16'hFFFE, 3);
    step();
    check_all("sat_hit", 12'h002, 16'h0101, 12'h002, 1, 15, 16'hFFFF, 3);
    step();
    check_all("sat_hold", 12'h002, 16'h0101, 12'h002, 1, 15, 16'hFFFF, 3);

    // Mid-run reset with all enables asserted.
    drive(1,1,0,0,12'h000);
    reset = 1'b0;
    step();
    check_all("midreset", 12'h000, 16'h0000, 12'h000, 0, 0, 0, 0);
    chk("midreset.imem_addr", 32'(imem_addr), 32'h0);

    // Released while running: first edge has rd_ok=0, so a bubble is loaded
    // even though the PC advances.
    reset = 1'b1;
    step();
    check_all("post_reset0", 12'h001, 16'h0000, 12'h001, 0, 0, 0, 0);
    step();
    check_all("post_reset1", 12'h002, 16'h0101, 12'h002, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
